// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared two-half-adder full-add cell, LSB first.
// Optional subtract mode via SERIAL_ADD_SUB_EN (adds the 'sub' port).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] areg, breg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic op_sub;
`ifdef SERIAL_ADD_SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    // Full add built from two half adders on the operand LSBs.
    logic ha1_s, ha1_c, ha2_s, ha2_c, c_next;
    assign ha1_s  = areg[0] ^ breg[0];
    assign ha1_c  = areg[0] & breg[0];
    assign ha2_s  = ha1_s ^ carry;
    assign ha2_c  = ha1_s & carry;
    assign c_next = ha1_c | ha2_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            areg  <= '0;
            breg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b and seed the carry.
                        areg  <= a;
                        breg  <= op_sub ? ~b : b;
                        carry <= op_sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= c_next;
                    sum   <= {ha2_s, sum[WIDTH-1:1]};
                    areg  <= areg >> 1;
                    breg  <= breg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= c_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
